// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: ALU opcodes, FSM encoding and
// instruction field helpers.
package instr_sequencer_pkg;

  localparam int unsigned InstrW = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_MOV  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StRun   = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Instruction word layout: {op[7:6], rsv[5:4], data[3:0]}
  function automatic logic [1:0] instr_op(input logic [InstrW-1:0] w);
    return w[7:6];
  endfunction

  function automatic logic [1:0] instr_rsv(input logic [InstrW-1:0] w);
    return w[5:4];
  endfunction

  function automatic logic [3:0] instr_data(input logic [InstrW-1:0] w);
    return w[3:0];
  endfunction

endpackage

// File: rtl/instr_sequencer_ram.sv
// Program RAM: one synchronous write port, one synchronous read port with a resettable
// output register; a same-address write and read returns the new data.
module instr_sequencer_ram
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [InstrW-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [InstrW-1:0] rdata
);

  logic [InstrW-1:0] mem [DEPTH];
  logic [InstrW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register holds its value when re is low so the last word stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Streams a stored program to the accumulator ALU, one qualified instruction per clock,
// with a program write port that is only open while the sequencer is idle or done.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [InstrW-1:0] prog_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              stop,
  output logic [InstrW-1:0] instruction,
  output logic              instr_valid,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LenW = AW + 1;
  localparam logic [AW:0] LenMax = LenW'(DEPTH);

  state_e      state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW:0]   len_sat;
  logic          last;

  assign wr_en   = prog_we && ((state_q == StIdle) || (state_q == StDone));
  assign len_sat = (prog_len > LenMax) ? LenMax : prog_len;
  assign last    = ({1'b0, pc_q} == (len_q - LenW'(1)));

  instr_sequencer_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en),
    .waddr(prog_addr),
    .wdata(prog_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(instruction)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; the read address always points at the word to be shown next cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    rd_en   = 1'b0;
    rd_addr = pc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start && !stop) begin
          if (prog_len == '0) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
            len_d   = len_sat;
            pc_d    = '0;
          end
        end
      end
      StFetch: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          state_d = StRun;
          rd_en   = 1'b1;
          rd_addr = pc_q;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (last) begin
          state_d = StDone;
        end else begin
          pc_d    = pc_q + AW'(1);
          rd_en   = 1'b1;
          rd_addr = pc_q + AW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = (state_d == StRun);
    busy_d  = (state_d == StFetch) || (state_d == StRun);
    done_d  = (state_d == StDone);
  end

  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a valid-gated accumulator ALU model.
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic       start;
  logic       stop;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(
    .DEPTH(16),
    .AW   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_len   (prog_len),
    .start      (start),
    .stop       (stop),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue log and ALU model, updated on every edge where instr_valid was high.
  logic [7:0] log_w  [1024];
  logic [3:0] log_pc [1024];
  int         n_valid = 0;
  logic [7:0] alu_a = 8'h00;
  logic [7:0] alu_b = 8'h00;
  logic       alu_clr = 1'b0;

  always @(posedge clk) begin
    if (alu_clr) begin
      alu_a <= 8'h00;
      alu_b <= 8'h00;
    end else if (rst_n && instr_valid) begin
      case (instruction[7:6])
        2'b00: alu_a <= alu_a + alu_b;
        2'b01: alu_a <= ~(alu_a & alu_b);
        2'b10: alu_a <= {4'h0, instruction[3:0]};
        default: begin
          alu_a <= alu_b;
          alu_b <= alu_a;
        end
      endcase
    end
    if (rst_n && instr_valid && n_valid < 1024) begin
      log_w[n_valid]  <= instruction;
      log_pc[n_valid] <= pc;
      n_valid         <= n_valid + 1;
    end
  end

  typedef struct {
    logic       start;
    logic       stop;
    logic [4:0] len;
    logic       exp_valid;
    logic [7:0] exp_instr;
    logic [3:0] exp_pc;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t tv [14];
  logic [7:0] prog [11] = '{8'hA3, 8'hC0, 8'h80, 8'h00, 8'h40, 8'hC0,
                            8'h81, 8'h00, 8'hC0, 8'h88, 8'h05};

  function automatic vec_t mk(input logic st, input logic sp, input logic [4:0] ln,
                              input logic v, input logic [7:0] ins, input logic [3:0] p,
                              input logic b, input logic d);
    vec_t r;
    r.start = st; r.stop = sp; r.len = ln;
    r.exp_valid = v; r.exp_instr = ins; r.exp_pc = p; r.exp_busy = b; r.exp_done = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] len);
    start = 1'b1; prog_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_alu();
    alu_clr = 1'b1;
    @(negedge clk);
    alu_clr = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int k = 0;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_pc(input string name, input logic [3:0] target, input int bound);
    int k = 0;
    while (!(instr_valid && pc == target) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, instr_valid && (pc == target)}, 32'd1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; stop = 1'b0;

    tv[0] = mk(1'b1, 1'b0, 5'd11, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      tv[i+1] = mk(1'b0, 1'b0, 5'd11, 1'b1, prog[i], 4'(i), 1'b1, 1'b0);
    end
    tv[12] = mk(1'b0, 1'b0, 5'd11, 1'b0, 8'h05, 4'd10, 1'b0, 1'b1);
    tv[13] = mk(1'b1, 1'b1, 5'd11, 1'b0, 8'h05, 4'd10, 1'b0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    check("reset_instr", {24'd0, instruction}, 32'h00);
    check("reset_flags", {28'd0, instr_valid, busy, done, 1'b0}, 32'h0);
    check("reset_pc", {28'd0, pc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) write_word(4'(i), prog[i]);

    // Full subtract program, cycle by cycle; last row is start+stop in DONE.
    clear_alu();
    base = n_valid;
    for (int i = 0; i < 14; i++) begin
      start = tv[i].start; stop = tv[i].stop; prog_len = tv[i].len;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check($sformatf("tv%0d_valid", i), {31'd0, instr_valid}, {31'd0, tv[i].exp_valid});
      check($sformatf("tv%0d_instr", i), {24'd0, instruction}, {24'd0, tv[i].exp_instr});
      check($sformatf("tv%0d_pc", i), {28'd0, pc}, {28'd0, tv[i].exp_pc});
      check($sformatf("tv%0d_busy", i), {31'd0, busy}, {31'd0, tv[i].exp_busy});
      check($sformatf("tv%0d_done", i), {31'd0, done}, {31'd0, tv[i].exp_done});
    end
    check("sub_count", n_valid - base, 32'd11);
    check("sub_alu", {24'd0, alu_a}, 32'h05);

    // Asynchronous reset in the middle of a run.
    pulse_start(5'd11);
    wait_pc("rst_wait_pc5", 4'd5, 20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_instr", {24'd0, instruction}, 32'h00);
    check("async_rst_flags", {29'd0, instr_valid, busy, done}, 32'h0);
    check("async_rst_pc", {28'd0, pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after_rst_idle", {29'd0, instr_valid, busy, done}, 32'h0);

    // Zero-length program.
    clear_alu();
    base = n_valid;
    pulse_start(5'd0);
    check("len0_done", {29'd0, instr_valid, busy, done}, 32'h1);
    repeat (3) @(negedge clk);
    check("len0_no_valid", n_valid - base, 32'd0);
    check("len0_alu", {24'd0, alu_a}, 32'h00);

    // Stop at pc=3: words 0..3 issue, then idle.
    base = n_valid;
    pulse_start(5'd11);
    wait_pc("stop_wait_pc3", 4'd3, 20);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_idle", {29'd0, instr_valid, busy, done}, 32'h0);
    check("stop_count", n_valid - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stop_word%0d", i), {24'd0, log_w[base+i]}, {24'd0, prog[i]});
    end

    // start and stop together in IDLE does nothing.
    start = 1'b1; stop = 1'b1; prog_len = 5'd11;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("startstop_idle", {29'd0, instr_valid, busy, done}, 32'h0);

    // Write while busy is dropped.
    pulse_start(5'd11);
    write_word(4'd0, 8'hFF);
    wait_done("busy_we_done", 30);
    base = n_valid;
    pulse_start(5'd1);
    repeat (3) @(negedge clk);
    check("busy_we_count", n_valid - base, 32'd1);
    check("busy_we_word", {24'd0, log_w[base]}, 32'hA3);

    // Write to addr 0 together with an accepted start is seen by the first read.
    base = n_valid;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h42;
    pulse_start(5'd1);
    prog_we = 1'b0;
    repeat (3) @(negedge clk);
    check("wfirst_count", n_valid - base, 32'd1);
    check("wfirst_word", {24'd0, log_w[base]}, 32'h42);

    // Full-depth program; length 20 saturates to 16, pc must not wrap.
    for (int i = 0; i < 16; i++) write_word(4'(i), (i % 2 == 0) ? 8'h81 : 8'h00);
    base = n_valid;
    pulse_start(5'd20);
    wait_done("full_done", 40);
    check("full_count", n_valid - base, 32'd16);
    check("full_pc_end", {28'd0, pc}, 32'd15);
    check("full_last_word", {24'd0, instruction}, 32'h00);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_pc%0d", i), {28'd0, log_pc[base+i]}, i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
